fnd_scan_ctrl: RTL and testbench

- Parametrised N-digit multiplexed 7-segment driver; successor to the fixed 4-digit FND display.
- Converts a binary value to BCD with a sequential double-dabble engine and scans digits at a programmable refresh rate.
- Adds leading-zero blanking, per-digit decimal points, PWM brightness and a raw-glyph mode for direction letters.
- Sits between the PWM/timer control logic and the board anode/segment pins.

---
 rtl/fnd_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// N-digit multiplexed 7-segment driver: sequential binary-to-BCD conversion,
// scanned anodes with PWM brightness, leading-zero blanking and raw glyph mode.
module fnd_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_DIV = 262144,
  parameter int BRIGHT_W    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [VAL_W-1:0]        value,
  input  logic                    raw_mode,
  input  logic [4*N_DIGITS-1:0]   raw_digits,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    busy,
  output logic                    ovf,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp
);

  // Scratch holds every decimal digit VAL_W bits can produce plus one spare
  // digit, so the top nibble never needs adjusting and nothing is truncated.
  localparam int DIG_CALC   = (VAL_W * 301) / 1000 + 1;
  localparam int SCR_DIGITS = ((DIG_CALC > N_DIGITS) ? DIG_CALC : N_DIGITS) + 1;
  localparam int SCR_W      = 4 * SCR_DIGITS;
  localparam int BCD_W      = 4 * N_DIGITS;
  localparam int ITER_W     = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int THR_W      = CNT_W + 1;
  localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SLOT       = REFRESH_DIV >> BRIGHT_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [VAL_W-1:0]    bin_q, bin_d;
  logic [SCR_W-1:0]    scr_q, scr_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic [SCR_W-5:0]    scr_adj;
  logic [N_DIGITS-1:0] lz_v;
  logic [THR_W-1:0]    thresh;
  logic                active;
  logic [3:0]          code;

  genvar gi;

  generate
    for (gi = 0; gi < SCR_DIGITS - 1; gi++) begin : g_adj
      assign scr_adj[4*gi +: 4] = (scr_q[4*gi +: 4] >= 4'd5) ?
                                  scr_q[4*gi +: 4] + 4'd3 : scr_q[4*gi +: 4];
    end
  endgenerate

  // lz_v[i]: digit i and everything above it are zero; digit 0 always shows.
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign lz_v[gi] = 1'b0;
      end else begin : g_upper
        assign lz_v[gi] = (bcd_q[BCD_W-1:4*gi] == '0);
      end
    end
  endgenerate

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0111000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b1111110;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = value;
          scr_d   = '0;
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d  = {scr_q[SCR_W-2:SCR_W-4], scr_adj, bin_q[VAL_W-1]};
        bin_d  = {bin_q[VAL_W-2:0], 1'b0};
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_W'(VAL_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = scr_q[BCD_W-1:0];
        ovf_d   = |scr_q[SCR_W-1:BCD_W];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    thresh = THR_W'((int'(brightness) + 1) * SLOT);
    active = ({1'b0, cnt_q} < thresh);

    // Overflow dashes take priority over blanking; raw mode bypasses both.
    if (raw_mode) begin
      code = raw_digits[4*idx_q +: 4];
    end else if (ovf_q) begin
      code = 4'hC;
    end else if (blank_lz && lz_v[idx_q]) begin
      code = 4'hF;
    end else begin
      code = bcd_q[4*idx_q +: 4];
    end

    an_d = '1;
    if (active) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = glyph(code);
    dp_d  = active ? ~dp_mask[idx_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with a short refresh period so scanning,
// conversion, blanking, overflow, raw glyphs and brightness fit in a few thousand cycles.
module tb_fnd_scan_ctrl;
  localparam int N  = 4;
  localparam int VW = 14;
  localparam int RD = 16;
  localparam int BW = 2;

  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S1    = 7'b1001111;
  localparam logic [6:0] S2    = 7'b0010010;
  localparam logic [6:0] S3    = 7'b0000110;
  localparam logic [6:0] S4    = 7'b1001100;
  localparam logic [6:0] S5    = 7'b0100100;
  localparam logic [6:0] S7    = 7'b0001111;
  localparam logic [6:0] S9    = 7'b0000100;
  localparam logic [6:0] GF    = 7'b0111000;
  localparam logic [6:0] GB    = 7'b1100000;
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic [VW-1:0]   value;
  logic            raw_mode;
  logic [4*N-1:0]  raw_digits;
  logic [N-1:0]    dp_mask;
  logic            blank_lz;
  logic [BW-1:0]   brightness;
  logic            busy;
  logic            ovf;
  logic [N-1:0]    an;
  logic [6:0]      seg;
  logic            dp;

  int vectors     = 0;
  int miscompares = 0;

  fnd_scan_ctrl #(
    .N_DIGITS(N), .VAL_W(VW), .REFRESH_DIV(RD), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .raw_mode(raw_mode), .raw_digits(raw_digits), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .brightness(brightness),
    .busy(busy), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int v, output int busy_cycles);
    value = VW'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
    $display("load value=%0d busy_cycles=%0d ovf=%0b", v, busy_cycles, ovf);
  endtask

  // Waits (bounded) for digit d's anode, then checks the segments shown with it.
  task automatic show_digit(input int d, input logic [6:0] exp_seg, input string tag);
    logic [N-1:0] want;
    int n;
    want = ~(N'(1) << d);
    n = 0;
    tick();
    while (an !== want && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_an"}, 32'(an), 32'(want));
    check(tag, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    int bc;
    int rises;
    int high_cnt;
    int act;
    int d0cnt;
    int multi;
    logic prev;
    logic [N-1:0] exp_an;
    logic exp_dp;

    reset = 1'b1; load = 1'b0; value = '0; raw_mode = 1'b0; raw_digits = '0;
    dp_mask = '0; blank_lz = 1'b0; brightness = 2'd3;
    repeat (3) tick();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(BLANK));
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;

    for (int k = 1; k <= 128; k++) begin
      tick();
      exp_an = ~(N'(1) << (((k - 1) / RD) % N));
      check("scan_an", 32'(an), 32'(exp_an));
      check("scan_seg", 32'(seg), 32'(S0));
    end
    check("idle_busy", 32'(busy), 32'd0);
    $display("idle scan 128 cycles done");

    do_load(1234, bc);
    check("busy_len_1234", bc, 15);
    check("ovf_1234", 32'(ovf), 32'd0);
    show_digit(0, S4, "d0_1234");
    show_digit(1, S3, "d1_1234");
    show_digit(2, S2, "d2_1234");
    show_digit(3, S1, "d3_1234");

    blank_lz = 1'b1;
    value = VW'(7);
    rises = 0;
    high_cnt = 0;
    prev = busy;
    for (int i = 0; i < 40; i++) begin
      load = (i == 0 || i == 6);
      tick();
      if (busy === 1'b1 && prev !== 1'b1) rises++;
      if (busy === 1'b1) high_cnt++;
      prev = busy;
    end
    load = 1'b0;
    $display("load value=7 with repeat load while busy, busy_pulses=%0d", rises);
    check("busy_pulses_7", rises, 1);
    check("busy_len_7", high_cnt, 15);
    show_digit(0, S7, "d0_7");
    show_digit(1, BLANK, "d1_7_lz");
    show_digit(2, BLANK, "d2_7_lz");
    show_digit(3, BLANK, "d3_7_lz");

    do_load(1005, bc);
    show_digit(0, S5, "d0_1005");
    show_digit(1, S0, "d1_1005");
    show_digit(3, S1, "d3_1005");

    do_load(0, bc);
    show_digit(0, S0, "d0_zero");
    show_digit(3, BLANK, "d3_zero_lz");

    do_load(9999, bc);
    check("ovf_9999", 32'(ovf), 32'd0);
    show_digit(3, S9, "d3_9999");
    do_load(10000, bc);
    check("ovf_10000", 32'(ovf), 32'd1);
    show_digit(0, DASH, "d0_10000");

    do_load(12000, bc);
    check("ovf_12000", 32'(ovf), 32'd1);
    show_digit(0, DASH, "d0_12000");
    show_digit(1, DASH, "d1_12000");
    show_digit(2, DASH, "d2_12000");
    show_digit(3, DASH, "d3_12000");
    do_load(5, bc);
    check("ovf_5", 32'(ovf), 32'd0);
    show_digit(0, S5, "d0_5");
    show_digit(1, BLANK, "d1_5_lz");

    raw_mode = 1'b1;
    raw_digits = 16'hA000;
    dp_mask = 4'b0010;
    show_digit(3, GF, "raw_d3_f");
    show_digit(0, S0, "raw_d0");
    for (int i = 0; i < 64; i++) begin
      tick();
      exp_dp = (an === 4'b1101) ? 1'b0 : 1'b1;
      check("raw_dp", 32'(dp), 32'(exp_dp));
    end
    $display("raw mode glyphs A000 dp_mask=0010 checked");
    raw_digits = 16'hDCB9;
    show_digit(0, S9, "raw_d0_9");
    show_digit(1, GB, "raw_d1_b");
    show_digit(2, DASH, "raw_d2_dash");
    show_digit(3, BLANK, "raw_d3_blank");

    raw_mode = 1'b0;
    blank_lz = 1'b0;
    dp_mask = '0;
    brightness = 2'd1;
    repeat (20) tick();
    act = 0; d0cnt = 0; multi = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (an !== 4'hF) act++;
      if (an === 4'b1110) d0cnt++;
      if ($countones(~an) > 1) multi++;
    end
    $display("brightness=1 active_cycles=%0d of 64", act);
    check("bright1_active", act, 32);
    check("bright1_digit0", d0cnt, 8);
    check("bright1_onehot", multi, 0);

    brightness = 2'd0;
    repeat (20) tick();
    act = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (an !== 4'hF) act++;
    end
    $display("brightness=0 active_cycles=%0d of 64", act);
    check("bright0_active", act, 16);

    brightness = 2'd3;
    do_load(1234, bc);
    value = VW'(999);
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    check("mid_shift_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    $display("reset asserted during conversion");
    check("abort_an", 32'(an), 32'hF);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_seg", 32'(seg), 32'(BLANK));
    check("abort_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    show_digit(0, S0, "abort_d0");
    show_digit(1, S0, "abort_d1");
    show_digit(2, S0, "abort_d2");
    show_digit(3, S0, "abort_d3");
    check("abort_busy_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
